answer_tx: RTL and testbench

Frame transmitter downstream of the answer-byte table. On a start request it walks the table address 0..NUM_BYTES-1 and captures each registered answer byte. It sends each byte as an 8N1 UART character on txd, LSB first. It optionally appends an XOR checksum byte. Between frames it parks the address on an unused slot so the table's per-frame side effects fire exactly once per frame.

---
 rtl/answer_tx_if.sv | 14 +
 rtl/answer_tx.sv | 129 ++++++++++++
 tb/tb_answer_tx.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/answer_tx_if.sv
// answer_tx_if: request, table and serial-line signals of the answer frame transmitter
// Signals: start (frame request), data (registered table byte), addr (table address),
//          txd (8N1 serial line), busy (frame in progress), done (one-clock frame-end pulse)
// master drives start/data (requester and table side); slave is the transmitter
interface answer_tx_if;
    logic       start;
    logic [7:0] data;
    logic [4:0] addr;
    logic       txd;
    logic       busy;
    logic       done;
    modport master (output start, data, input addr, txd, busy, done);
    modport slave  (input start, data, output addr, txd, busy, done);
endinterface

// File: rtl/answer_tx.sv
// answer_tx: walks the answer-byte table and sends each byte as an 8N1 character, plus optional XOR checksum
// Ports: clk   - clock
//        rst   - asynchronous active-low reset
//        bus   - answer_tx_if.slave: start in, data in, addr out, txd out, busy out, done out
module answer_tx #(
    parameter int         CLK_DIV   = 16,
    parameter int         NUM_BYTES = 18,
    parameter logic [4:0] PARK_ADDR = 5'd31,
    parameter bit         CHK_EN    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    answer_tx_if.slave bus
);
    localparam logic [1:0]  IDLE     = 2'd0;
    localparam logic [1:0]  FETCH1   = 2'd1;
    localparam logic [1:0]  FETCH2   = 2'd2;
    localparam logic [1:0]  SHIFT    = 2'd3;
    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [4:0]  IDX_LAST = 5'(NUM_BYTES - 1);
    localparam logic [4:0]  IDX_CHK  = 5'(NUM_BYTES);

    logic [1:0]  state_q, state_d;
    logic [4:0]  addr_q, addr_d;
    logic [4:0]  idx_q, idx_d;
    logic        txd_q, txd_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  chk_q, chk_d;
    logic [9:0]  sh_q, sh_d;
    logic [15:0] div_q, div_d;
    logic [3:0]  bit_q, bit_d;
    logic        is_chk, div_end, more, chk_next;
    logic [7:0]  cur_byte;

    // The checksum character uses the index one past the last table byte.
    assign is_chk   = CHK_EN && idx_q == IDX_CHK;
    assign cur_byte = is_chk ? chk_q : bus.data;
    assign div_end  = div_q == DIV_LAST;
    assign more     = idx_q < IDX_LAST;
    assign chk_next = CHK_EN && idx_q == IDX_LAST;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        txd_d   = txd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        chk_d   = chk_q;
        sh_d    = sh_q;
        div_d   = div_q;
        bit_d   = bit_q;
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (bus.start) begin
                    addr_d  = 5'd0;
                    busy_d  = 1'b1;
                    chk_d   = 8'h00;
                    idx_d   = 5'd0;
                    state_d = FETCH1;
                end
            end
            FETCH1: state_d = FETCH2;
            FETCH2: begin
                sh_d    = {1'b1, cur_byte, 1'b0};
                txd_d   = 1'b0;
                chk_d   = is_chk ? chk_q : chk_q ^ cur_byte;
                div_d   = 16'd0;
                bit_d   = 4'd0;
                state_d = SHIFT;
            end
            SHIFT: begin
                div_d = div_end ? 16'd0 : div_q + 16'd1;
                if (div_end && bit_q != 4'd9) begin
                    sh_d  = sh_q >> 1;
                    txd_d = sh_q[1];
                    bit_d = bit_q + 4'd1;
                end
                // End of stop bit: next table byte, then checksum, then frame end.
                if (div_end && bit_q == 4'd9) begin
                    if (more || chk_next) begin
                        idx_d   = idx_q + 5'd1;
                        addr_d  = more ? addr_q + 5'd1 : PARK_ADDR;
                        state_d = FETCH1;
                    end else begin
                        addr_d  = PARK_ADDR;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= PARK_ADDR;
            idx_q   <= 5'd0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            chk_q   <= 8'h00;
            sh_q    <= 10'h3ff;
            div_q   <= 16'd0;
            bit_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            chk_q   <= chk_d;
            sh_q    <= sh_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
        end
    end

    assign bus.addr = addr_q;
    assign bus.txd  = txd_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_answer_tx.sv
// tb_answer_tx: directed bench for answer_tx with a UART decoder scoreboard per instance
// Instance a: CLK_DIV=4, NUM_BYTES=18, checksum on; instance b: CLK_DIV=2, NUM_BYTES=3, checksum off
module tb_answer_tx;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    answer_tx_if bus_a ();
    answer_tx_if bus_b ();

    answer_tx #(.CLK_DIV(4), .NUM_BYTES(18), .PARK_ADDR(5'd31), .CHK_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    answer_tx #(.CLK_DIV(2), .NUM_BYTES(3), .PARK_ADDR(5'd31), .CHK_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] tab(input logic [4:0] a);
        return a == 5'd0 ? 8'h07 : a == 5'd16 ? 8'h03 : a == 5'd17 ? 8'h00 :
               a > 5'd17 ? 8'hee : 8'(a * 10);
    endfunction

    // Registered table: data follows addr by one clock.
    always @(posedge clk) begin
        bus_a.data <= tab(bus_a.addr);
        bus_b.data <= tab(bus_b.addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input int w);
        logic [7:0] x = 8'h00;
        int nb = w ? 3 : 18;
        for (int a = 0; a < nb; a++) begin
            if (w != 0) qb.push_back(tab(5'(a)));
            else qa.push_back(tab(5'(a)));
            x ^= tab(5'(a));
        end
        if (w == 0) qa.push_back(x);
    endtask

    function automatic logic txd_of(input int w);
        return w != 0 ? bus_b.txd : bus_a.txd;
    endfunction

    function automatic logic busy_of(input int w);
        return w != 0 ? bus_b.busy : bus_a.busy;
    endfunction

    // UART decoder: every bit must hold for the full bit period; inter-character gap within a frame is 2 clocks.
    task automatic mon(input int w);
        int d = w != 0 ? 2 : 4;
        int gap = 0;
        int pend;
        bit first = 1'b1;
        bit bad;
        bit aborted;
        logic [9:0] sh;
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (!busy_of(w)) first = 1'b1;
            if (txd_of(w) !== 1'b0) begin
                gap++;
                continue;
            end
            if (!first) chk(w != 0 ? "b_gap" : "a_gap", gap, 2);
            first = 1'b0;
            bad = 1'b0;
            aborted = 1'b0;
            sh = '1;
            for (int c = 0; c < 10 * d; c++) begin
                if (c > 0) @(negedge clk);
                if (!rst) begin
                    aborted = 1'b1;
                    break;
                end
                if (c % d == 0) sh[c / d] = txd_of(w);
                else if (txd_of(w) !== sh[c / d]) bad = 1'b1;
            end
            gap = 0;
            if (aborted) begin
                first = 1'b1;
                continue;
            end
            chk(w != 0 ? "b_framing" : "a_framing", {29'd0, sh[9], sh[0], bad}, 32'b100);
            pend = w != 0 ? qb.size() : qa.size();
            chk(w != 0 ? "b_char_expected" : "a_char_expected", 32'(pend > 0), 1);
            if (pend > 0) begin
                exp = w != 0 ? qb.pop_front() : qa.pop_front();
                chk(w != 0 ? "b_byte" : "a_byte", sh[8:1], exp);
            end
        end
    endtask

    initial mon(0);
    initial mon(1);

    // mode 0: plain frame; 1: stray start pulses at clocks 100/500; 2: start held across done
    task automatic run_a(input int mode);
        int bad_addr = 0;
        int bad_busy = 0;
        int bad_done = 0;
        push_frame(0);
        bus_a.start = 1'b1;
        @(negedge clk);
        for (int n = 0; n <= 799; n++) begin
            if (n > 0) @(negedge clk);
            bus_a.start = (mode == 1 && (n == 100 || n == 500)) || (mode == 2 && n >= 790);
            if (mode == 2 && n == 790) push_frame(0);
            if (n < 799 && bus_a.addr !== (n < 756 ? 5'(n / 42) : 5'd31)) bad_addr++;
            if (n < 799 && bus_a.busy !== (n < 798)) bad_busy++;
            if (bus_a.done !== (n == 798)) bad_done++;
            if (n == 1) chk("a_txd_high_before_start_bit", bus_a.txd, 1);
            if (n == 2) chk("a_first_start_bit", bus_a.txd, 0);
            if (n == 798) chk("a_done_at_798", bus_a.done, 1);
            if (n == 799) begin
                chk("a_busy_after_done", bus_a.busy, mode == 2);
                chk("a_addr_after_done", bus_a.addr, mode == 2 ? 0 : 31);
            end
        end
        bus_a.start = 1'b0;
        chk("a_addr_profile", bad_addr, 0);
        chk("a_busy_profile", bad_busy, 0);
        chk("a_done_profile", bad_done, 0);
        if (mode == 2) begin
            int cyc = 0;
            while (bus_a.done !== 1'b1 && cyc < 1000) begin
                @(negedge clk);
                cyc++;
            end
            chk("a_back_to_back_len", cyc, 798);
            @(negedge clk);
        end
    endtask

    initial begin
        int bad;
        int cyc;
        rst = 1'b0;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_txd", bus_a.txd, 1);
        chk("reset_addr", bus_a.addr, 31);
        chk("reset_busy", bus_a.busy, 0);
        chk("reset_done", bus_a.done, 0);
        rst = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus_a.txd !== 1'b1 || bus_a.addr !== 5'd31 || bus_a.busy !== 1'b0 || bus_a.done !== 1'b0) bad++;
        end
        chk("idle_hold", bad, 0);

        run_a(0);
        run_a(1);
        run_a(2);

        push_frame(0);
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        cyc = 0;
        while (bus_a.addr !== 5'd5 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        chk("a_reach_byte5", bus_a.addr, 5);
        repeat (20) @(negedge clk);
        chk("a_txd_low_before_abort", bus_a.txd, 0);
        #2 rst = 1'b0;
        #1;
        chk("abort_txd", bus_a.txd, 1);
        chk("abort_addr", bus_a.addr, 31);
        chk("abort_busy", bus_a.busy, 0);
        qa.delete();
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus_a.done !== 1'b0) bad++;
        end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (bus_a.done !== 1'b0 || bus_a.txd !== 1'b1) bad++;
        end
        chk("abort_no_done", bad, 0);
        run_a(0);

        push_frame(1);
        bus_b.start = 1'b1;
        @(negedge clk);
        bus_b.start = 1'b0;
        bad = 0;
        for (int n = 0; n <= 67; n++) begin
            if (n > 0) @(negedge clk);
            if (bus_b.addr !== (n < 66 ? 5'(n / 22) : 5'd31)) bad++;
            if (n < 66 && bus_b.addr > 5'd2) bad++;
            if (bus_b.busy !== (n < 66)) bad++;
            if (bus_b.done !== (n == 66)) bad++;
            if (n == 66) chk("b_done_at_66", bus_b.done, 1);
        end
        chk("b_profile", bad, 0);
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
